// File: rtl/io_out_buffer.sv
// Output-side I/O write buffer: queues CPU character writes for the UART and forwards the stop write once drained.
// Optional feature: define IO_OUT_BUFFER_DROP_CNT_EN to count characters rejected while the FIFO is full.
module io_out_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] addr_from_cpu,
    input  logic [7:0]  data_from_cpu,
    input  logic        is_store_from_cpu,
    input  logic        io_buffer_full,
    output logic [7:0]  data_to_hci,
    output logic        is_store_to_hci,
    output logic        is_stop_to_hci,
    output logic        is_full_to_fc,
    output logic        is_stopped,
    output logic [15:0] drop_cnt
);

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_STOPPED = 1'b1
    } state_t;

    localparam logic [ADDR_W:0] C_FULL = (ADDR_W + 1)'(DEPTH);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_head;
    logic [ADDR_W-1:0] r_tail;
    logic [ADDR_W:0]   r_count;
    logic              r_stop_pending;
    logic [7:0]        r_data;
    logic              r_store;
    logic              r_stop;
    logic              r_full;

    logic w_io_sel;
    logic w_char_wr;
    logic w_stop_wr;
    logic w_run;
    logic w_is_full;
    logic w_accepting;
    logic w_push;
    logic w_pop;
    logic w_emit_stop;
    logic w_unused_addr;

    assign w_io_sel    = is_store_from_cpu && (addr_from_cpu[17:16] == 2'b11);
    assign w_char_wr   = w_io_sel && (addr_from_cpu[2:0] == 3'b000) && (data_from_cpu != 8'h00);
    assign w_stop_wr   = w_io_sel && (addr_from_cpu[2:0] == 3'b100);
    assign w_run       = (r_state == ST_RUN);
    assign w_is_full   = (r_count == C_FULL);
    // Characters arriving after the stop write are silently discarded.
    assign w_accepting = rdy && w_run && !r_stop_pending && w_char_wr;
    assign w_push      = w_accepting && !w_is_full;
    assign w_pop       = rdy && w_run && (r_count != '0) && !io_buffer_full;
    assign w_emit_stop = rdy && w_run && r_stop_pending && (r_count == '0) && !io_buffer_full;
    assign w_unused_addr = ^{addr_from_cpu[31:18], addr_from_cpu[15:3]};

    always_comb begin
        w_state_nxt = r_state;
        if (w_emit_stop) begin
            w_state_nxt = ST_STOPPED;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Storage has no reset; resetting the pointers is what discards the contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= data_from_cpu;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_stop_pending <= 1'b0;
            r_data         <= 8'h00;
            r_store        <= 1'b0;
            r_stop         <= 1'b0;
            r_full         <= 1'b0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + ADDR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (ADDR_W + 1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (rdy && w_run && w_stop_wr) begin
                r_stop_pending <= 1'b1;
            end
            // Both terms are gated by rdy, so a frozen cycle never repeats a write.
            r_store <= w_pop || w_emit_stop;
            if (w_pop) begin
                r_data <= r_mem[r_head];
                r_stop <= 1'b0;
            end else if (w_emit_stop) begin
                r_data <= 8'h00;
                r_stop <= 1'b1;
            end
            if (rdy) begin
                r_full <= w_is_full;
            end
        end
    end

`ifdef IO_OUT_BUFFER_DROP_CNT_EN
    logic [15:0] r_drop_cnt;
    logic        w_drop;

    assign w_drop = w_accepting && w_is_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop_cnt <= 16'h0000;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'h0001;
        end
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign drop_cnt = 16'h0000;
`endif

    assign data_to_hci     = r_data;
    assign is_store_to_hci = r_store;
    assign is_stop_to_hci  = r_stop;
    assign is_full_to_fc   = r_full;
    assign is_stopped      = (r_state == ST_STOPPED);

endmodule

// File: tb/tb_io_out_buffer.sv
// Scoreboard bench for io_out_buffer: expected {stop, byte} pairs are queued as stimulus is driven
// and popped whenever the UART-side write pulse is observed.
module tb_io_out_buffer;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic [31:0] addr_from_cpu;
    logic [7:0]  data_from_cpu;
    logic        is_store_from_cpu;
    logic        io_buffer_full;
    logic [7:0]  data_to_hci;
    logic        is_store_to_hci;
    logic        is_stop_to_hci;
    logic        is_full_to_fc;
    logic        is_stopped;
    logic [15:0] drop_cnt;

    logic [8:0]  exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic        rdy_q    = 1'b1;

`ifdef IO_OUT_BUFFER_DROP_CNT_EN
    localparam logic [15:0] EXP_DROP = 16'd1;
`else
    localparam logic [15:0] EXP_DROP = 16'd0;
`endif

    io_out_buffer #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .addr_from_cpu    (addr_from_cpu),
        .data_from_cpu    (data_from_cpu),
        .is_store_from_cpu(is_store_from_cpu),
        .io_buffer_full   (io_buffer_full),
        .data_to_hci      (data_to_hci),
        .is_store_to_hci  (is_store_to_hci),
        .is_stop_to_hci   (is_stop_to_hci),
        .is_full_to_fc    (is_full_to_fc),
        .is_stopped       (is_stopped),
        .drop_cnt         (drop_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    // checker
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // scoreboard monitor
    always @(posedge clk) rdy_q <= rdy;

    always @(negedge clk) begin
        if (rst) begin
            if (!rdy_q) begin
                check("no_pulse_rdy_low", 32'(is_store_to_hci), 32'd0);
            end
            if (is_store_to_hci) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {23'd0, is_stop_to_hci, data_to_hci}, 32'h1FF);
                end else begin
                    check("out_byte", {23'd0, is_stop_to_hci, data_to_hci}, 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // drivers
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cpu_write(input logic [31:0] addr, input logic [7:0] data);
        addr_from_cpu     = addr;
        data_from_cpu     = data;
        is_store_from_cpu = 1'b1;
        @(posedge clk);
        #1;
        is_store_from_cpu = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({"drain_", tag}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},    32'(data_to_hci),     32'd0);
        check({tag, "_store"},   32'(is_store_to_hci), 32'd0);
        check({tag, "_stop"},    32'(is_stop_to_hci),  32'd0);
        check({tag, "_full"},    32'(is_full_to_fc),   32'd0);
        check({tag, "_stopped"}, 32'(is_stopped),      32'd0);
        check({tag, "_drop"},    32'(drop_cnt),        32'd0);
    endtask

    initial begin
        int pulses;
        int nwr;
        rst = 1'b0;
        rdy = 1'b1;
        addr_from_cpu = 32'h0;
        data_from_cpu = 8'h0;
        is_store_from_cpu = 1'b0;
        io_buffer_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);

        // single byte latency: pulse appears two edges after the write is sampled
        exp_q.push_back({1'b0, 8'h41});
        addr_from_cpu = 32'h0003_0000;
        data_from_cpu = 8'h41;
        is_store_from_cpu = 1'b1;
        @(posedge clk);
        #1;
        is_store_from_cpu = 1'b0;
        @(negedge clk);
        check("lat_no_bypass", 32'(is_store_to_hci), 32'd0);
        @(negedge clk);
        check("lat_pulse", 32'(is_store_to_hci), 32'd1);
        check("lat_data", 32'(data_to_hci), 32'h41);
        @(negedge clk);
        check("lat_single_cycle", 32'(is_store_to_hci), 32'd0);
        @(posedge clk);
        #1;
        wait_drain("single", 5);

        // zero byte is ignored
        cpu_write(32'h0003_0000, 8'h00);
        idle(4);
        check("zero_not_full", 32'(is_full_to_fc), 32'd0);

        // fill past capacity while the UART is busy
        io_buffer_full = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            if (i <= 16) exp_q.push_back({1'b0, 8'(i)});
            cpu_write(32'h0003_0000, 8'(i));
        end
        idle(2);
        check("full_flag", 32'(is_full_to_fc), 32'd1);
        check("drop_count", 32'(drop_cnt), 32'(EXP_DROP));
        check("full_no_output", 32'(exp_q.size()), 32'd16);
        io_buffer_full = 1'b0;
        pulses = 0;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (is_store_to_hci) pulses++;
        end
        check("throughput_pulses", 32'(pulses), 32'd16);
        @(posedge clk);
        #1;
        idle(2);
        check("full_cleared", 32'(is_full_to_fc), 32'd0);
        wait_drain("full", 5);

        // stream with toggling back-pressure and a rdy-low gap
        nwr = 0;
        for (int i = 0; i < 30; i++) begin
            logic [7:0] b;
            io_buffer_full = ((i / 2) % 2) == 1;
            rdy = !(i == 7 || i == 8);
            if (rdy && nwr < 10) begin
                b = 8'($urandom_range(1, 255));
                exp_q.push_back({1'b0, b});
                addr_from_cpu = (nwr % 2 == 0) ? 32'h0003_0000 : 32'hABC3_0008;
                data_from_cpu = b;
                is_store_from_cpu = 1'b1;
                nwr++;
            end else begin
                is_store_from_cpu = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        is_store_from_cpu = 1'b0;
        rdy = 1'b1;
        io_buffer_full = 1'b0;
        wait_drain("stream", 40);

        // reset asserted mid-drain
        io_buffer_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 2) exp_q.push_back({1'b0, 8'hA0 + 8'(i)});
            cpu_write(32'h0003_0000, 8'hA0 + 8'(i));
        end
        io_buffer_full = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        check("pre_reset_drained", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(1);
        exp_q.push_back({1'b0, 8'h42});
        cpu_write(32'h0003_0000, 8'h42);
        wait_drain("after_reset", 6);
        idle(4);

        // stop write forwarded only after queued characters
        io_buffer_full = 1'b1;
        exp_q.push_back({1'b0, 8'h11});
        cpu_write(32'h0003_0000, 8'h11);
        exp_q.push_back({1'b0, 8'h22});
        cpu_write(32'h0003_0000, 8'h22);
        exp_q.push_back({1'b0, 8'h33});
        cpu_write(32'h0003_0000, 8'h33);
        exp_q.push_back({1'b1, 8'h00});
        cpu_write(32'h0003_0004, 8'h01);
        cpu_write(32'h0003_0000, 8'h55);
        idle(2);
        check("not_stopped_yet", 32'(is_stopped), 32'd0);
        io_buffer_full = 1'b0;
        wait_drain("stop", 10);
        idle(1);
        check("stopped", 32'(is_stopped), 32'd1);
        check("stop_drop_uncounted", 32'(drop_cnt), 32'd0);
        cpu_write(32'h0003_0000, 8'h66);
        cpu_write(32'h0003_0004, 8'h00);
        idle(5);
        check("still_stopped", 32'(is_stopped), 32'd1);
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/io_out_buffer.md
# io_out_buffer

Output-side I/O write buffer, directly downstream of the CPU memory bus (`mem_a`/`mem_dout`/`mem_wr`) and upstream of the UART host interface. It captures CPU byte writes to 0x30000 (character out) and 0x30004 (program stop) and queues characters in a FIFO. It drains one byte per cycle while `io_buffer_full` is low, so CPU stores never wait on the UART. It forwards the stop write only after every preceding character has drained.

## Interface
Parameters:
- DEPTH, 16: FIFO entries; must be a power of two, at least 2.
- ADDR_W, 4: log2(DEPTH).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- rdy  in  1  global ready; when low, all state and outputs are frozen.
- addr_from_cpu  in  32  CPU memory address; bits [17:0] are decoded.
- data_from_cpu  in  8  CPU write byte.
- is_store_from_cpu  in  1  CPU write strobe (`mem_wr`).
- io_buffer_full  in  1  UART transmit buffer full.
- data_to_hci  out  8  byte presented to the UART.
- is_store_to_hci  out  1  one-cycle write pulse to the UART.
- is_stop_to_hci  out  1  qualifies `is_store_to_hci` as the 0x30004 stop write.
- is_full_to_fc  out  1  FIFO full; advisory back-pressure to the fetcher.
- is_stopped  out  1  stop has been forwarded.
- drop_cnt  out  16  count of rejected character pushes (see Configuration).

## Operation
- Decode, in the same cycle as the strobe:
  - char_wr = is_store_from_cpu & addr[17:16]==2'b11 & addr[2:0]==3'b000 & data_from_cpu!=0.
  - stop_wr = is_store_from_cpu & addr[17:16]==2'b11 & addr[2:0]==3'b100.
  - Character writes of 0x00 are ignored, never queued.
- FIFO: head and tail pointers are ADDR_W bits wide and wrap modulo DEPTH. `count` is ADDR_W+1 bits wide.
- Push: char_wr & count<DEPTH & state==RUN. When full, the byte is dropped.
- Pop: count>0 & !io_buffer_full & state==RUN.
- Simultaneous push and pop: both take effect and count is unchanged. The full test uses pre-pop `count`, so a push while count==DEPTH is dropped even when a pop occurs in the same cycle.
- States:
  - RUN: normal operation. On stop_wr, set `stop_pending`; further char_wr after stop_wr are dropped and not counted.
  - RUN with stop_pending & count==0 & !io_buffer_full: emit the stop (is_store_to_hci=1, is_stop_to_hci=1, data_to_hci=0x00) and go to STOPPED.
  - STOPPED: absorbing state. No pushes, no pops, is_stopped=1. Left only by reset.
- A stop_wr arriving while already in STOPPED is ignored.

## Timing
- Reset values: data_to_hci=0, is_store_to_hci=0, is_stop_to_hci=0, is_full_to_fc=0, is_stopped=0, drop_cnt=0, count=0, head=tail=0, stop_pending=0, state=RUN.
- All outputs are registered.
- Push latency: a char_wr sampled at edge N makes is_store_to_hci high for the cycle after edge N+1, at the earliest. There is no bypass from input to output.
- Throughput: one byte per cycle while io_buffer_full stays low.
- is_store_to_hci is a single-cycle pulse per popped byte and is deasserted in any cycle without a pop.
- is_full_to_fc reflects the registered count==DEPTH, i.e. it lags the push that filled the FIFO by one cycle.
- io_buffer_full is sampled at each edge. If it rises, the byte already issued stands and no new pop occurs.
- rdy low: no state changes and outputs hold their values, except is_store_to_hci, which is forced to 0 so a write never repeats.
- Reset asserted mid-drain: the FIFO contents are discarded and all outputs take their reset values immediately (asynchronous reset).

## Configuration
- IO_OUT_BUFFER_DROP_CNT_EN defined: drop_cnt increments on each rejected non-zero char_wr issued in RUN before the stop (FIFO full). It saturates at 0xFFFF.
- Not defined: the counter logic is omitted and drop_cnt is tied to 0.

## Test plan
- Reset, then write 0x41 to 0x30000 with io_buffer_full=0 -> is_store_to_hci pulses for one cycle with data 0x41, two edges after the write.
- Write 0x00 to 0x30000 -> no push and no output pulse; count stays 0.
- Hold io_buffer_full=1 and write 17 bytes 0x01..0x11 with DEPTH=16 -> is_full_to_fc=1, and drop_cnt=1 when the macro is defined (0 when not). Release io_buffer_full -> exactly 0x01..0x10 emitted in order, one per cycle, with correct pointer wrap.
- Queue 3 bytes, write stop to 0x30004, then write 0x55 -> three characters drain, then one pulse with is_stop_to_hci=1 and data 0x00; is_stopped=1; 0x55 is never emitted.
- Stream bytes while toggling io_buffer_full every 2 cycles and pulsing rdy low mid-stream -> no byte is duplicated or lost, and no pulse occurs while rdy is low.
- Assert rst low with 5 bytes queued -> outputs clear immediately. After release, a new write of 0x42 is the first byte out.
